// File: rtl/spi_pwm_config.sv
// SPI mode-0 write target holding the PWM configuration registers.
// Optional register readback on cipo is built when SPI_READBACK_EN is defined.
module spi_pwm_config #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_done
);

    localparam int         NREG_IMPL  = (NUM_REGS < 5) ? 5 : NUM_REGS;
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [SYNC_STAGES-1:0]   r_sclk_sync;
    logic [SYNC_STAGES-1:0]   r_copi_sync;
    logic [SYNC_STAGES-1:0]   r_ncs_sync;
    logic                     r_sclk_hist;
    logic                     r_ncs_hist;
    logic [15:0]              r_shift;
    logic [4:0]               r_cnt;
    logic                     r_txn_done;
    logic [7:0]               r_regs [NREG_IMPL];

    logic       w_sclk_s, w_copi_s, w_ncs_s;
    logic       w_sclk_rise, w_ncs_rise, w_ncs_fall;
    logic       w_shift_en, w_wr;
    logic [6:0] w_addr;

    // Synchronisers reset to the idle bus state so reset release creates no false edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sclk_hist <= 1'b0;
            r_ncs_hist  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_ncs_hist  <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_hist;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_hist;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_ncs_fall) w_state_next = S_SHIFT;
            S_SHIFT:  if (w_ncs_rise) w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // A clock edge coinciding with the closing ncs edge is not part of the frame.
    assign w_shift_en = (r_state == S_SHIFT) && w_sclk_rise && !w_ncs_rise;
    assign w_addr     = r_shift[14:8];
    assign w_wr       = (r_state == S_COMMIT) && (r_cnt == 5'd16) && r_shift[15]
                        && ({1'b0, w_addr} < NUM_REGS_B);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_txn_done <= 1'b0;
            for (int i = 0; i < NREG_IMPL; i++) r_regs[i] <= '0;
        end else begin
            r_txn_done <= w_wr;
            if ((r_state == S_IDLE) && w_ncs_fall) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_shift_en) begin
                r_shift <= {r_shift[14:0], w_copi_s};
                r_cnt   <= (r_cnt == 5'd17) ? 5'd17 : r_cnt + 5'd1;
            end
            for (int i = 0; i < NREG_IMPL; i++) begin
                if (w_wr && (w_addr == 7'(i))) r_regs[i] <= r_shift[7:0];
            end
        end
    end

    assign en_reg_out_7_0  = r_regs[0];
    assign en_reg_out_15_8 = r_regs[1];
    assign en_reg_pwm_7_0  = r_regs[2];
    assign en_reg_pwm_15_8 = r_regs[3];
    assign pwm_duty_cycle  = r_regs[4];
    assign txn_done        = r_txn_done;

`ifdef SPI_READBACK_EN
    logic       r_rd_act;
    logic [7:0] r_rd_data;
    logic       r_cipo;
    logic       w_sclk_fall;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_mux;

    assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;
    // Address as it will stand once the 8th bit lands in the shift register.
    assign w_rd_addr   = {r_shift[5:0], w_copi_s};

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_addr == 7'(i)) w_rd_mux = r_regs[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_act  <= 1'b0;
            r_rd_data <= '0;
            r_cipo    <= 1'b0;
        end else if (w_ncs_rise || (r_state != S_SHIFT)) begin
            r_rd_act <= 1'b0;
            r_cipo   <= 1'b0;
        end else if (w_shift_en && (r_cnt == 5'd7)) begin
            r_rd_act  <= ~r_shift[6];
            r_rd_data <= w_rd_mux;
        end else if (r_rd_act && w_sclk_fall) begin
            r_cipo    <= r_rd_data[7];
            r_rd_data <= {r_rd_data[6:0], 1'b0};
        end
    end

    assign cipo = r_cipo;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_config.sv
// Directed bench for spi_pwm_config: frame-level register model checked every cycle,
// plus literal expectations after each scenario.
module tb_spi_pwm_config;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       txn_done;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_regs [5];
    logic       m_txn = 1'b0;
    bit         chk_en = 1'b0;
    logic       cipo_samp [16];

    spi_pwm_config #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .txn_done(txn_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the frame-level model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("reg0", en_reg_out_7_0, m_regs[0]);
            check("reg1", en_reg_out_15_8, m_regs[1]);
            check("reg2", en_reg_pwm_7_0, m_regs[2]);
            check("reg3", en_reg_pwm_15_8, m_regs[3]);
            check("reg4", pwm_duty_cycle, m_regs[4]);
            check("txn_done", {7'b0, txn_done}, {7'b0, m_txn});
`ifndef SPI_READBACK_EN
            check("cipo_tied", {7'b0, cipo}, 8'h00);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SCLK half period of 4 clk cycles (clk/8). cipo is sampled just before each rise.
    task automatic send_bits(input logic [31:0] v, input int n, input int base);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            tick(4);
            if (base + (n - 1 - i) < 16) cipo_samp[base + (n - 1 - i)] = cipo;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    // Write becomes visible, with txn_done, 4 clk edges after the ncs pin rises.
    task automatic end_frame(input bit commit, input int a, input logic [7:0] d);
        tick(4);
        ncs = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (commit) begin
            m_regs[a] = d;
            m_txn = 1'b1;
        end
        @(posedge clk);
        #1 m_txn = 1'b0;
        tick(6);
    endtask

    task automatic frame(input logic [31:0] v, input int n);
        bit commit;
        commit = (n == 16) && v[15] && (v[14:8] < 7'd5);
        ncs = 1'b0;
        tick(4);
        send_bits(v, n, 0);
        end_frame(commit, int'(v[14:8]), v[7:0]);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        tick(3);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rd_exp;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        tick(3);
        chk_en = 1'b1;
        check("rst_reg0", en_reg_out_7_0, 8'h00);
        check("rst_reg4", pwm_duty_cycle, 8'h00);
        check("rst_txn", {7'b0, txn_done}, 8'h00);
        check("rst_cipo", {7'b0, cipo}, 8'h00);
        rst_n = 1'b1;
        tick(4);

        frame(32'h8480, 16);
        check("duty_80", pwm_duty_cycle, 8'h80);
        check("reg0_untouched", en_reg_out_7_0, 8'h00);

        frame(32'h80F0, 16);
        frame(32'h810F, 16);
        frame(32'h82AA, 16);
        frame(32'h8355, 16);
        check("lit_reg0", en_reg_out_7_0, 8'hF0);
        check("lit_reg1", en_reg_out_15_8, 8'h0F);
        check("lit_reg2", en_reg_pwm_7_0, 8'hAA);
        check("lit_reg3", en_reg_pwm_15_8, 8'h55);

        frame(32'h8A12, 16);
        frame(32'h0421, 15);
        frame(32'h18477, 17);
        check("discard_duty", pwm_duty_cycle, 8'h80);
        check("discard_reg0", en_reg_out_7_0, 8'hF0);

        ncs = 1'b0;
        tick(4);
        send_bits(32'h80, 8, 0);
        reset_pulse();
        send_bits(32'hFF, 8, 8);
        end_frame(1'b0, 0, 8'h00);
        check("abort_reg0", en_reg_out_7_0, 8'h00);
        check("abort_duty", pwm_duty_cycle, 8'h00);
        frame(32'h8011, 16);
        check("after_abort_reg0", en_reg_out_7_0, 8'h11);

        frame(32'h8233, 16);
        frame(32'h0200, 16);
        check("read_keeps_reg2", en_reg_pwm_7_0, 8'h33);
`ifdef SPI_READBACK_EN
        rd_exp = 8'h33;
        for (int j = 0; j < 8; j++)
            check("cipo_bit", {7'b0, cipo_samp[8 + j]}, {7'b0, rd_exp[7 - j]});
`else
        rd_exp = 8'h00;
        for (int j = 0; j < 8; j++)
            check("cipo_bit_tied", {7'b0, cipo_samp[8 + j]}, {7'b0, rd_exp[7 - j]});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
